// File: rtl/nx_ram_hw_arb_pkg.sv
// -----------------------------------------------------------------------------
// nx_ram_hw_arb_pkg
// Shared types and helpers for the 1RW RAM hardware-port arbiter:
//   state_e    : arbiter FSM state (INIT sweep, RUN arbitration, DRAIN reads)
//   rsp_ent_t  : response-pipe entry {vld, id}; id is sized for up to 8
//                requesters so the struct does not depend on N_REQ
//   id_width() : requester-id width, $clog2(n) with a floor of 1
// -----------------------------------------------------------------------------
package nx_ram_hw_arb_pkg;

  localparam int ID_MAX_W = 3;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
  } rsp_ent_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nx_rr_picker.sv
// -----------------------------------------------------------------------------
// nx_rr_picker
// Combinational round-robin select: grants the first asserted request at or
// after the pointer, wrapping modulo N_REQ.
// Ports:
//   req_i  [N_REQ]  request vector
//   ptr_i  [IDW]    round-robin start position
//   gnt_o  [N_REQ]  one-hot grant (all zero when no request)
//   id_o   [IDW]    index of the winner (0 when no request)
//   any_o           at least one request present
// -----------------------------------------------------------------------------
module nx_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDW-1:0]   id_o,
  output logic             any_o
);

  logic           found_s;
  logic [IDW-1:0] idx_s;

  // Scan from the pointer; the first hit wins.
  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_s = IDW'((int'(ptr_i) + i) % N_REQ);
      if (!found_s && req_i[idx_s]) begin
        found_s = 1'b1;
        id_o    = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      gnt_o[id_o] = 1'b1;
    end else begin
      gnt_o = '0;
    end
    any_o = found_s;
  end

endmodule

// File: rtl/nx_ram_1rw_hw_arbiter.sv
// -----------------------------------------------------------------------------
// nx_ram_1rw_hw_arbiter
// Shares the hw_* port of a 1RW indirect-access RAM wrapper between N_REQ
// requesters (round-robin), yields idle cycles on hw_yield, sweeps the whole
// memory with RESET_DATA after reset / on init_start, and returns read data to
// the issuing requester RAM_LATENCY+1 cycles after its grant.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req/req_we/req_addr/req_wdat  per-requester request and packed fields
//   gnt                      one-hot combinational accept
//   rsp_vld/rsp_dat          one-hot read-valid and read data
//   init_start/init_busy     re-init request pulse / sweep pending or active
//   hw_add/hw_we/hw_bwe/hw_cs/hw_din  registered wrapper command (bwe all ones)
//   hw_dout/hw_yield         wrapper read data / idle-cycle request
// Optional feature macro NX_RAM_HW_ARB_PERF_EN adds grant_cnt, yield_cnt
// (saturating 16-bit counters) and their synchronous clear cnt_clr.
// -----------------------------------------------------------------------------
module nx_ram_1rw_hw_arbiter
  import nx_ram_hw_arb_pkg::*;
#(
  parameter int                     N_REQ       = 4,
  parameter int                     N_ADDR_BITS = 14,
  parameter int                     N_DATA_BITS = 38,
  parameter int                     N_ENTRIES   = 16384,
  parameter int                     RAM_LATENCY = 2,
  parameter logic [N_DATA_BITS-1:0] RESET_DATA  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0]             req_we,
  input  logic [N_REQ*N_ADDR_BITS-1:0] req_addr,
  input  logic [N_REQ*N_DATA_BITS-1:0] req_wdat,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             rsp_vld,
  output logic [N_DATA_BITS-1:0]       rsp_dat,
  input  logic                         init_start,
  output logic                         init_busy,
  output logic [N_ADDR_BITS-1:0]       hw_add,
  output logic                         hw_we,
  output logic [N_DATA_BITS-1:0]       hw_bwe,
  output logic                         hw_cs,
  output logic [N_DATA_BITS-1:0]       hw_din,
  input  logic [N_DATA_BITS-1:0]       hw_dout,
  input  logic                         hw_yield
`ifdef NX_RAM_HW_ARB_PERF_EN
  ,
  input  logic                         cnt_clr,
  output logic [N_REQ*16-1:0]          grant_cnt,
  output logic [15:0]                  yield_cnt
`endif
);

  localparam int                     IDW       = id_width(N_REQ);
  localparam logic [N_ADDR_BITS-1:0] LAST_ADDR = N_ADDR_BITS'(N_ENTRIES - 1);

  state_e                 state_q, state_d;
  logic [N_ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]         ptr_q, ptr_d;

  logic                   hw_cs_q, hw_cs_d;
  logic                   hw_we_q, hw_we_d;
  logic [N_ADDR_BITS-1:0] hw_add_q, hw_add_d;
  logic [N_DATA_BITS-1:0] hw_din_q, hw_din_d;

  // Entry k of the pipe is in flight for the read accepted k+1 cycles ago;
  // the last entry lines up with hw_dout.
  rsp_ent_t               pipe_q [RAM_LATENCY+1];
  rsp_ent_t               push_ent_s;
  rsp_ent_t               out_ent_s;
  logic                   push_s;
  logic                   pipe_empty_s;

  logic [N_REQ-1:0]       pick_gnt_s;
  logic [IDW-1:0]         pick_id_s;
  logic                   pick_any_s;

  nx_rr_picker #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_picker (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt_s),
    .id_o  (pick_id_s),
    .any_o (pick_any_s)
  );

  // Pipeline occupancy across all stages, including the output stage.
  always_comb begin
    pipe_empty_s = 1'b1;
    for (int k = 0; k <= RAM_LATENCY; k++) begin
      if (pipe_q[k].vld) begin
        pipe_empty_s = 1'b0;
      end else begin
        pipe_empty_s = pipe_empty_s;
      end
    end
  end

  // FSM next state, arbitration and next hw command.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    hw_cs_d  = 1'b0;
    hw_we_d  = 1'b0;
    hw_add_d = '0;
    hw_din_d = '0;
    gnt      = '0;
    push_s   = 1'b0;
    case (state_q)
      INIT: begin
        if (!hw_yield) begin
          hw_cs_d  = 1'b1;
          hw_we_d  = 1'b1;
          hw_add_d = cnt_q;
          hw_din_d = RESET_DATA;
          cnt_d    = cnt_q + N_ADDR_BITS'(1);
          if (cnt_q == LAST_ADDR) begin
            state_d = RUN;
          end else begin
            state_d = INIT;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      RUN: begin
        // init_start wins over any pending request in the same cycle.
        if (init_start) begin
          cnt_d   = '0;
          state_d = pipe_empty_s ? INIT : DRAIN;
        end else if (!hw_yield && pick_any_s) begin
          gnt      = pick_gnt_s;
          hw_cs_d  = 1'b1;
          hw_we_d  = req_we[pick_id_s];
          hw_add_d = req_addr[pick_id_s*N_ADDR_BITS +: N_ADDR_BITS];
          hw_din_d = req_wdat[pick_id_s*N_DATA_BITS +: N_DATA_BITS];
          push_s   = !req_we[pick_id_s];
          ptr_d    = (pick_id_s == IDW'(N_REQ - 1)) ? '0 : pick_id_s + IDW'(1);
        end else begin
          gnt = '0;
        end
      end
      DRAIN: begin
        if (pipe_empty_s) begin
          cnt_d   = '0;
          state_d = INIT;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = INIT;
      end
    endcase
  end

  // New pipe entry for an accepted read.
  always_comb begin
    push_ent_s.vld = push_s;
    push_ent_s.id  = ID_MAX_W'(pick_id_s);
  end

  // State, counters, hw command registers and response pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      ptr_q    <= '0;
      hw_cs_q  <= 1'b0;
      hw_we_q  <= 1'b0;
      hw_add_q <= '0;
      hw_din_q <= '0;
      for (int k = 0; k <= RAM_LATENCY; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      hw_cs_q  <= hw_cs_d;
      hw_we_q  <= hw_we_d;
      hw_add_q <= hw_add_d;
      hw_din_q <= hw_din_d;
      pipe_q[0] <= push_ent_s;
      for (int k = 1; k <= RAM_LATENCY; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  assign out_ent_s = pipe_q[RAM_LATENCY];

  // Route wrapper read data to the requester that issued it.
  always_comb begin
    rsp_vld = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_vld[i] = out_ent_s.vld && (out_ent_s.id == ID_MAX_W'(i));
    end
    if (out_ent_s.vld) begin
      rsp_dat = hw_dout;
    end else begin
      rsp_dat = '0;
    end
  end

  assign init_busy = (state_q != RUN);
  assign hw_cs     = hw_cs_q;
  assign hw_we     = hw_we_q;
  assign hw_add    = hw_add_q;
  assign hw_din    = hw_din_q;
  assign hw_bwe    = '1;

`ifdef NX_RAM_HW_ARB_PERF_EN
  logic [N_REQ*16-1:0] grant_cnt_q;
  logic [15:0]         yield_cnt_q;

  // Saturating grant and lost-to-yield counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q <= '0;
      yield_cnt_q <= '0;
    end else if (cnt_clr) begin
      grant_cnt_q <= '0;
      yield_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && (grant_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
          grant_cnt_q[i*16 +: 16] <= grant_cnt_q[i*16 +: 16] + 16'd1;
        end
      end
      if ((state_q == RUN) && hw_yield && (yield_cnt_q != 16'hFFFF)) begin
        yield_cnt_q <= yield_cnt_q + 16'd1;
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign yield_cnt = yield_cnt_q;
`endif

endmodule

// File: tb/tb_nx_ram_1rw_hw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nx_ram_1rw_hw_arbiter
// Bench for nx_ram_1rw_hw_arbiter with N_ENTRIES=16. A behavioural 1RW RAM
// (latency 2 from hw_cs) sits on the hw_* port. Expected read responses
// {cycle, id, data} are queued when a read is driven and compared when
// rsp_vld fires.
// -----------------------------------------------------------------------------
module tb_nx_ram_1rw_hw_arbiter;

  localparam int NR = 4;
  localparam int AW = 14;
  localparam int DW = 38;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdat = '0;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     rsp_vld;
  logic [DW-1:0]     rsp_dat;
  logic              init_start = 1'b0;
  logic              init_busy;
  logic [AW-1:0]     hw_add;
  logic              hw_we;
  logic [DW-1:0]     hw_bwe;
  logic              hw_cs;
  logic [DW-1:0]     hw_din;
  logic [DW-1:0]     hw_dout;
  logic              hw_yield = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int            cyc;
    int            id;
    logic [DW-1:0] dat;
  } exp_t;
  exp_t sb[$];

  nx_ram_1rw_hw_arbiter #(
    .N_REQ       (NR),
    .N_ADDR_BITS (AW),
    .N_DATA_BITS (DW),
    .N_ENTRIES   (16),
    .RAM_LATENCY (2),
    .RESET_DATA  ('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdat   (req_wdat),
    .gnt        (gnt),
    .rsp_vld    (rsp_vld),
    .rsp_dat    (rsp_dat),
    .init_start (init_start),
    .init_busy  (init_busy),
    .hw_add     (hw_add),
    .hw_we      (hw_we),
    .hw_bwe     (hw_bwe),
    .hw_cs      (hw_cs),
    .hw_din     (hw_din),
    .hw_dout    (hw_dout),
    .hw_yield   (hw_yield)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM wrapper: data valid two cycles after the hw_cs cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd1 = '0;
  logic [DW-1:0] rd2 = '0;
  always @(posedge clk) begin
    if (hw_cs && hw_we) mem[hw_add] <= hw_din;
    rd1 <= (hw_cs && !hw_we) ? mem[hw_add] : '0;
    rd2 <= rd1;
  end
  assign hw_dout = rd2;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdat[i*DW +: DW] = d;
  endtask

  // Response monitor: every rsp_vld must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rsp_vld !== '0) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 64'(rsp_vld), 64'd0);
      end else begin
        exp_t e;
        logic [NR-1:0] ev;
        e = sb.pop_front();
        ev = 4'b0001 << e.id;
        check_eq("rsp_cycle", 64'(cyc), 64'(e.cyc));
        check_eq("rsp_vld", 64'(rsp_vld), 64'(ev));
        check_eq("rsp_dat", 64'(rsp_dat), 64'(e.dat));
      end
    end
  end

  // Full 16-entry sweep starting in the current (first post-reset) cycle.
  task automatic sweep_check(input logic [NR-1:0] rq);
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) next_cyc();
      req = (c < 16) ? rq : 4'b0000;
      smp();
      if (c < 16) begin
        check_eq("sweep_gnt", 64'(gnt), 64'd0);
        check_eq("sweep_busy", 64'(init_busy), 64'd1);
      end else if (c == 16) begin
        check_eq("sweep_busy_drop", 64'(init_busy), 64'd0);
      end
      if (c >= 1 && c <= 16) begin
        check_eq("sweep_cs", 64'(hw_cs), 64'd1);
        check_eq("sweep_we", 64'(hw_we), 64'd1);
        check_eq("sweep_add", 64'(hw_add), 64'(c - 1));
        check_eq("sweep_din", 64'(hw_din), 64'd0);
      end
      if (c == 17) check_eq("sweep_idle_cs", 64'(hw_cs), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd_exp [NR];
    logic          found;
    rd_exp[0] = 38'h2A; rd_exp[1] = 38'h2A; rd_exp[2] = 38'h7; rd_exp[3] = 38'h7;

    // Reset held with all requests up: no grants, busy, outputs cleared.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      smp();
      check_eq("rst_gnt", 64'(gnt), 64'd0);
      check_eq("rst_busy", 64'(init_busy), 64'd1);
      check_eq("rst_cs", 64'(hw_cs), 64'd0);
      check_eq("rst_rsp", 64'(rsp_vld), 64'd0);
    end
    check_eq("hw_bwe", 64'(hw_bwe), 64'h3F_FFFF_FFFF);

    // Partial sweep, reset while the counter holds 7.
    next_cyc();
    rst = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) next_cyc();
      smp();
      if (c >= 1) check_eq("part_add", 64'(hw_add), 64'(c - 1));
    end
    rst = 1'b1;
    #1;
    check_eq("part_rst_cs", 64'(hw_cs), 64'd0);
    check_eq("part_rst_add", 64'(hw_add), 64'd0);
    for (int i = 0; i < 5; i++) next_cyc();
    rst = 1'b0;
    sweep_check(4'b1111);

    // req0 write 0x12 <- 0x2A, then req0 read 0x12.
    next_cyc();
    req = 4'b0001; set_req(0, 1'b1, 14'h12, 38'h2A);
    smp();
    check_eq("wr_gnt", 64'(gnt), 64'b0001);
    next_cyc();
    set_req(0, 1'b0, 14'h12, 38'h0);
    smp();
    check_eq("rd_gnt", 64'(gnt), 64'b0001);
    check_eq("wr_cs", 64'(hw_cs), 64'd1);
    check_eq("wr_we", 64'(hw_we), 64'd1);
    check_eq("wr_add", 64'(hw_add), 64'h12);
    check_eq("wr_din", 64'(hw_din), 64'h2A);
    sb.push_back('{cyc + 3, 0, 38'h2A});
    // req3 write 5 <- 7 (moves pointer back to 0).
    next_cyc();
    req = 4'b1000; set_req(3, 1'b1, 14'h5, 38'h7);
    smp();
    check_eq("wr3_gnt", 64'(gnt), 64'b1000);
    check_eq("rd_we", 64'(hw_we), 64'd0);
    check_eq("rd_add", 64'(hw_add), 64'h12);
    next_cyc();
    req = 4'b0000;
    for (int i = 0; i < 4; i++) next_cyc();

    // All four requesters read for 8 cycles: strict rotation.
    set_req(0, 1'b0, 14'h12, 38'h0);
    set_req(1, 1'b0, 14'h12, 38'h0);
    set_req(2, 1'b0, 14'h5, 38'h0);
    set_req(3, 1'b0, 14'h5, 38'h0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cyc();
      req = 4'b1111;
      smp();
      check_eq("rr_gnt", 64'(gnt), 64'(4'b0001 << (k % 4)));
      sb.push_back('{cyc + 3, k % 4, rd_exp[k % 4]});
    end

    // hw_yield for two cycles with req1 pending.
    next_cyc();
    req = 4'b0010; set_req(1, 1'b1, 14'h1, 38'h11); hw_yield = 1'b1;
    smp();
    check_eq("yld_gnt0", 64'(gnt), 64'd0);
    next_cyc();
    smp();
    check_eq("yld_gnt1", 64'(gnt), 64'd0);
    check_eq("yld_cs0", 64'(hw_cs), 64'd0);
    next_cyc();
    hw_yield = 1'b0;
    smp();
    check_eq("yld_gnt_after", 64'(gnt), 64'b0010);
    check_eq("yld_cs1", 64'(hw_cs), 64'd0);
    next_cyc();
    req = 4'b0000;
    smp();
    check_eq("yld_issue_cs", 64'(hw_cs), 64'd1);
    check_eq("yld_issue_add", 64'(hw_add), 64'h1);
    check_eq("yld_issue_din", 64'(hw_din), 64'h11);
    for (int i = 0; i < 4; i++) next_cyc();

    // Read then init_start: drain, deliver response, restart sweep at 0.
    req = 4'b0001; set_req(0, 1'b0, 14'h12, 38'h0);
    smp();
    check_eq("dr_rd_gnt", 64'(gnt), 64'b0001);
    sb.push_back('{cyc + 3, 0, 38'h2A});
    next_cyc();
    init_start = 1'b1;
    smp();
    check_eq("dr_start_gnt", 64'(gnt), 64'd0);
    next_cyc();
    init_start = 1'b0;
    smp();
    check_eq("dr_busy", 64'(init_busy), 64'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      next_cyc();
      smp();
      check_eq("dr_gnt", 64'(gnt), 64'd0);
      if (hw_cs) found = 1'b1;
    end
    check_eq("dr_restart_seen", 64'(found), 64'd1);
    check_eq("dr_restart_add", 64'(hw_add), 64'd0);
    check_eq("dr_restart_we", 64'(hw_we), 64'd1);
    check_eq("dr_rsp_done", 64'(sb.size()), 64'd0);
    req = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      next_cyc();
      smp();
      if (!init_busy) found = 1'b1;
    end
    check_eq("dr_sweep_done", 64'(found), 64'd1);

    // Reset with a read in flight: response discarded, sweep restarts.
    next_cyc();
    req = 4'b0001;
    smp();
    check_eq("rr_rd_gnt", 64'(gnt), 64'b0001);
    next_cyc();
    req = 4'b0000; rst = 1'b1;
    smp();
    check_eq("rr_rst_cs", 64'(hw_cs), 64'd0);
    check_eq("rr_rst_busy", 64'(init_busy), 64'd1);
    for (int i = 0; i < 4; i++) next_cyc();
    next_cyc();
    rst = 1'b0;
    sweep_check(4'b0000);
    for (int i = 0; i < 4; i++) next_cyc();
    check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
